// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execute ALU.
// Opcodes, CCR bit positions and controller state encoding.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_NOT  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_MOV  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SETC = 4'd11;
    localparam logic [3:0] OP_CLRC = 4'd12;
    localparam logic [3:0] OP_PASS = 4'd13;
    localparam logic [3:0] OP_LDM  = 4'd14;
    localparam logic [3:0] OP_MUL  = 4'd15;

    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// done_o marks the final step; product_o carries that step's value.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*N-1:0] product_o
);

    localparam int CW = $clog2(N) + 1;

    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   a_q;
    logic [2*N-1:0] p_q;
    logic [2*N-1:0] p_step;
    logic [N:0]     sum;
    logic           busy_q;

    // Low half holds the remaining multiplier bits, high half accumulates.
    always_comb begin
        sum    = {1'b0, p_q[2*N-1:N]}
               + {1'b0, (p_q[0] ? a_q : {N{1'b0}})};
        p_step = {sum, p_q[N-1:1]};
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == CW'(1));
    assign product_o = p_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            p_q    <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(N);
            a_q    <= a_i;
            p_q    <= {{N{1'b0}}, b_i};
        end else if (busy_q) begin
            p_q   <= p_step;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_seq.sv
// Registered valid/ready execute ALU owning the C/Z/N flag register.
// Define ALU_MUL_EN to build the iterative multiplier for op 15.
module alu_exec_seq
    import alu_pkg::*;
#(
    parameter int N       = 16,
    parameter int SHAMT_W = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [N-1:0] src,
    input  logic [N-1:0] dst,
    input  logic [N-1:0] imm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic [2:0]   flags
);

    localparam logic [SHAMT_W-1:0] SH_N = SHAMT_W'(N);

    logic [N-1:0]       result_q, result_d;
    logic [2:0]         flags_q, flags_d;
    logic               valid_q, valid_d;
    logic               idle;
    logic               accept;
    logic               is_mul;
    logic [N-1:0]       alu_r;
    logic [2:0]         alu_f;
    logic               alu_c;
    logic               alu_zn;
    logic [N:0]         wide;
    logic [SHAMT_W-1:0] sh;

    assign sh       = imm[SHAMT_W-1:0];
    assign in_ready = idle && !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        alu_r  = result_q;
        alu_c  = flags_q[FLAG_C];
        alu_zn = 1'b0;
        wide   = '0;
        case (op)
            OP_NOT: begin
                alu_r  = ~src;
                alu_zn = 1'b1;
            end
            OP_INC: begin
                wide   = {1'b0, src} + (N+1)'(1);
                alu_r  = wide[N-1:0];
                alu_c  = wide[N];
                alu_zn = 1'b1;
            end
            OP_DEC: begin
                alu_r  = src - N'(1);
                alu_c  = (src == '0);
                alu_zn = 1'b1;
            end
            OP_MOV, OP_PASS: alu_r = src;
            OP_ADD: begin
                wide   = {1'b0, src} + {1'b0, dst};
                alu_r  = wide[N-1:0];
                alu_c  = wide[N];
                alu_zn = 1'b1;
            end
            OP_SUB: begin
                alu_r  = src - dst;
                alu_c  = (src < dst);
                alu_zn = 1'b1;
            end
            OP_AND: begin
                alu_r  = src & dst;
                alu_zn = 1'b1;
            end
            OP_OR: begin
                alu_r  = src | dst;
                alu_zn = 1'b1;
            end
            // The extra bit of "wide" catches the last bit shifted out.
            OP_SHL: begin
                alu_zn = 1'b1;
                if (sh == '0) begin
                    alu_r = src;
                end else if (sh >= SH_N) begin
                    alu_r = '0;
                    alu_c = 1'b0;
                end else begin
                    wide  = {1'b0, src} << sh;
                    alu_r = wide[N-1:0];
                    alu_c = wide[N];
                end
            end
            OP_SHR: begin
                alu_zn = 1'b1;
                if (sh == '0) begin
                    alu_r = src;
                end else if (sh >= SH_N) begin
                    alu_r = '0;
                    alu_c = 1'b0;
                end else begin
                    wide  = {src, 1'b0} >> sh;
                    alu_r = wide[N:1];
                    alu_c = wide[0];
                end
            end
            OP_SETC: alu_c = 1'b1;
            OP_CLRC: alu_c = 1'b0;
            OP_LDM:  alu_r = imm;
            default: ;
        endcase
        alu_f         = flags_q;
        alu_f[FLAG_C] = alu_c;
        if (alu_zn) begin
            alu_f[FLAG_Z] = (alu_r == '0);
            alu_f[FLAG_N] = alu_r[N-1];
        end
    end

`ifdef ALU_MUL_EN
    state_t         state_q, state_d;
    logic           mul_start;
    logic           mul_busy;
    logic           mul_done;
    logic [2*N-1:0] mul_prod;
    logic [N-1:0]   hi_q, hi_d;

    assign is_mul    = (op == OP_MUL);
    assign mul_start = accept && is_mul;
    assign idle      = (state_q == ST_IDLE) && !mul_busy;
    assign result_hi = hi_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (flush || mul_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        if (accept && !is_mul) hi_d = '0;
        if (mul_done && !flush) hi_d = mul_prod[2*N-1:N];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
        end
    end

    alu_mul_iter #(.N(N)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .abort_i   (flush),
        .a_i       (src),
        .b_i       (dst),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`else
    assign is_mul    = 1'b0;
    assign idle      = 1'b1;
    assign result_hi = '0;
`endif

    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = valid_q;
        if (valid_q && out_ready) valid_d = 1'b0;
        if (accept && !is_mul) begin
            result_d = alu_r;
            flags_d  = alu_f;
            valid_d  = 1'b1;
        end
`ifdef ALU_MUL_EN
        if (mul_done) begin
            result_d        = mul_prod[N-1:0];
            flags_d[FLAG_C] = |mul_prod[2*N-1:N];
            flags_d[FLAG_Z] = (mul_prod == '0);
            flags_d[FLAG_N] = mul_prod[N-1];
            valid_d         = 1'b1;
        end
`endif
        // A flush drops the pending beat but never touches the datapath.
        if (flush) begin
            result_d = result_q;
            flags_d  = flags_q;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    assign result    = result_q;
    assign flags     = flags_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed self-checking bench for alu_exec_seq.
// Flags are written {C,Z,N}; the MUL scenarios build with ALU_MUL_EN.
module tb_alu_exec_seq;
    import alu_pkg::*;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [N-1:0] src = '0;
    logic [N-1:0] dst = '0;
    logic [N-1:0] imm = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result;
    logic [N-1:0] result_hi;
    logic [2:0]   flags;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src       (src),
        .dst       (dst),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    logic [3:0]   t_op  [21] = '{OP_SUB, OP_SHL, OP_SHR, OP_SETC, OP_SHR,
                                 OP_SETC, OP_SHL, OP_CLRC, OP_DEC, OP_NOT,
                                 OP_AND, OP_OR, OP_LDM, OP_MOV, OP_PASS,
                                 OP_INC, OP_ADD, OP_NOP, OP_SHL, OP_SHR,
                                 OP_SUB};
    logic [N-1:0] t_src [21] = '{16'h0003, 16'h8001, 16'h0002, 16'h0000,
                                 16'hFFFF, 16'h0000, 16'h00F0, 16'h0000,
                                 16'h0000, 16'h00FF, 16'hF0F0, 16'h0000,
                                 16'h0000, 16'h1234, 16'hABCD, 16'h7FFF,
                                 16'h0001, 16'h5555, 16'h0003, 16'h8000,
                                 16'h0005};
    logic [N-1:0] t_dst [21] = '{16'h0005, 16'h0000, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0FF0, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                 16'h0002, 16'h5555, 16'h0000, 16'h0000,
                                 16'h0005};
    logic [N-1:0] t_imm [21] = '{16'h0000, 16'h0001, 16'h0001, 16'h0000,
                                 16'h0010, 16'h0000, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                 16'h8000, 16'h0000, 16'h0000, 16'h0000,
                                 16'h0000, 16'h5555, 16'h000F, 16'h000F,
                                 16'h0000};
    logic [N-1:0] t_res [21] = '{16'hFFFE, 16'h0002, 16'h0001, 16'h0001,
                                 16'h0000, 16'h0000, 16'h00F0, 16'h00F0,
                                 16'hFFFF, 16'hFF00, 16'h00F0, 16'h0000,
                                 16'h8000, 16'h1234, 16'hABCD, 16'h8000,
                                 16'h0003, 16'h0003, 16'h8000, 16'h0001,
                                 16'h0000};
    logic [2:0]   t_flg [21] = '{3'b101, 3'b100, 3'b000, 3'b100, 3'b010,
                                 3'b110, 3'b100, 3'b000, 3'b101, 3'b101,
                                 3'b100, 3'b110, 3'b110, 3'b110, 3'b110,
                                 3'b001, 3'b000, 3'b000, 3'b101, 3'b000,
                                 3'b010};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [N-1:0] s,
                         input logic [N-1:0] d, input logic [N-1:0] i);
        in_valid = 1'b1;
        op       = o;
        src      = s;
        dst      = d;
        imm      = i;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if (result !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_result: got %h want 0000", result);
        end
        n_cmp++;
        if (result_hi !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_hi: got %h want 0000", result_hi);
        end
        n_cmp++;
        if (flags !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000", flags);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL add_ready: got %b want 1", in_ready);
        end
        cyc();
        in_valid = 1'b0;
        n_cmp++;
        if (result !== 16'h0000 || flags !== 3'b110) begin
            n_bad++;
            $display("FAIL add_result: got %h/%b want 0000/110",
                     result, flags);
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL add_valid: got %b want 1", out_valid);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL add_pulse: got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            drive(t_op[i], t_src[i], t_dst[i], t_imm[i]);
            cyc();
            n_cmp++;
            if (result !== t_res[i] || flags !== t_flg[i]) begin
                n_bad++;
                $display("FAIL vec%0d op%0d: got %h/%b want %h/%b",
                         i, t_op[i], result, flags, t_res[i], t_flg[i]);
            end
            n_cmp++;
            if (out_valid !== 1'b1 || result_hi !== 16'h0000) begin
                n_bad++;
                $display("FAIL vec%0d_valid_hi: got %b/%h want 1/0000",
                         i, out_valid, result_hi);
            end
        end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(OP_ADD, 16'h0010, 16'h0020, 16'h0000);
        cyc();
        drive(OP_MOV, 16'h5555, 16'h0000, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                result !== 16'h0030) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got rdy=%b vld=%b res=%h want 0/1/0030",
                         k, in_ready, out_valid, result);
            end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: got %b want 1", in_ready);
        end
        cyc();
        in_valid = 1'b0;
        n_cmp++;
        if (result !== 16'h5555 || out_valid !== 1'b1 || flags !== 3'b000) begin
            n_bad++;
            $display("FAIL bp_next: got %h/%b/%b want 5555/1/000",
                     result, out_valid, flags);
        end
        cyc();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(OP_ADD, 16'h0001, 16'h0001, 16'h0000);
        cyc();
        flush = 1'b1;
        drive(OP_MOV, 16'h7777, 16'h0000, 16'h0000);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_ready: got %b want 0", in_ready);
        end
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 16'h0002 || flags !== 3'b000) begin
            n_bad++;
            $display("FAIL flush_state: got %b/%h/%b want 0/0002/000",
                     out_valid, result, flags);
        end
        out_ready = 1'b1;
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_noaccept: got %b want 0", out_valid);
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        logic [N-1:0] a  [3] = '{16'hFFFF, 16'h0000, 16'h1234};
        logic [N-1:0] b  [3] = '{16'hFFFF, 16'h0005, 16'h0100};
        logic [N-1:0] lo [3] = '{16'h0001, 16'h0000, 16'h3400};
        logic [N-1:0] hi [3] = '{16'hFFFE, 16'h0000, 16'h0012};
        logic [2:0]   fl [3] = '{3'b100, 3'b010, 3'b100};
        int lat;
        int stall_bad;
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            drive(OP_MUL, a[v], b[v], 16'h0000);
            cyc();
            in_valid  = 1'b0;
            lat       = 1;
            stall_bad = 0;
            while (out_valid !== 1'b1 && lat < 40) begin
                if (in_ready !== 1'b0) stall_bad++;
                cyc();
                lat++;
            end
            n_cmp++;
            if (lat != 17) begin
                n_bad++;
                $display("FAIL mul%0d_latency: got %0d want 17", v, lat);
            end
            n_cmp++;
            if (stall_bad != 0) begin
                n_bad++;
                $display("FAIL mul%0d_stall: got %0d ready cycles want 0",
                         v, stall_bad);
            end
            n_cmp++;
            if (result !== lo[v] || result_hi !== hi[v] || flags !== fl[v]) begin
                n_bad++;
                $display("FAIL mul%0d_result: got %h_%h/%b want %h_%h/%b",
                         v, result_hi, result, flags, hi[v], lo[v], fl[v]);
            end
            cyc();
        end
    endtask

    task automatic test_mul_flush();
        int seen;
        out_ready = 1'b1;
        drive(OP_MUL, 16'h0005, 16'h0007, 16'h0000);
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mulflush_ctl: got vld=%b rdy=%b want 0/1",
                     out_valid, in_ready);
        end
        n_cmp++;
        if (flags !== 3'b100 || result !== 16'h3400 || result_hi !== 16'h0012) begin
            n_bad++;
            $display("FAIL mulflush_keep: got %h_%h/%b want 0012_3400/100",
                     result_hi, result, flags);
        end
        seen = 0;
        repeat (20) begin
            if (out_valid === 1'b1) seen++;
            cyc();
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL mulflush_quiet: got %0d beats want 0", seen);
        end
        drive(OP_NOP, 16'h0000, 16'h0000, 16'h0000);
        cyc();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || flags !== 3'b100 || result !== 16'h3400) begin
            n_bad++;
            $display("FAIL mulflush_nop: got %b/%b/%h want 1/100/3400",
                     out_valid, flags, result);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mulflush_pulse: got %b want 0", out_valid);
        end
    endtask
`else
    task automatic test_op15();
        out_ready = 1'b1;
        drive(OP_SUB, 16'h0003, 16'h0005, 16'h0000);
        cyc();
        drive(OP_MUL, 16'h1234, 16'h0100, 16'h0000);
        cyc();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || result !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL op15_beat: got %b/%h want 1/FFFE", out_valid, result);
        end
        n_cmp++;
        if (flags !== 3'b101 || result_hi !== 16'h0000) begin
            n_bad++;
            $display("FAIL op15_flags: got %b/%h want 101/0000",
                     flags, result_hi);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL op15_pulse: got %b want 0", out_valid);
        end
    endtask
`endif

    task automatic test_async_reset();
        int seen;
        out_ready = 1'b1;
`ifdef ALU_MUL_EN
        drive(OP_MUL, 16'h00FF, 16'h00FF, 16'h0000);
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
`else
        drive(OP_SUB, 16'h0003, 16'h0005, 16'h0000);
        cyc();
        in_valid = 1'b0;
`endif
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (flags !== 3'b000 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_flags: got %b/%b want 000/0", flags, out_valid);
        end
        n_cmp++;
        if (result !== 16'h0000 || result_hi !== 16'h0000) begin
            n_bad++;
            $display("FAIL arst_data: got %h_%h want 0000_0000",
                     result_hi, result);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_ready: got %b want 1", in_ready);
        end
        seen = 0;
        repeat (20) begin
            if (out_valid === 1'b1) seen++;
            cyc();
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL arst_quiet: got %0d beats want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_flush();
`ifdef ALU_MUL_EN
        test_mul();
        test_mul_flush();
`else
        test_op15();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Registered, handshaked successor to the single-cycle execute ALU. Parametrised in data width.
- Owns the CCR (C/Z/N) flag register.
- Adds an iterative multi-cycle multiplier and valid/ready flow control, so the stage can stall and be stalled.
- Sits between the ID/EX pipeline register and the EX/MEM register. Sources arrive already forwarded.

Parameters:
- N, 16, data width in bits (≥4).
- SHAMT_W, $clog2(N)+1, width of the shift-amount field taken from imm.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  operation presented
- in_ready  out  1  stage can accept
- op  in  4  opcode (see Behaviour)
- src  in  N  first operand
- dst  in  N  second operand
- imm  in  N  immediate / shift amount
- out_valid  out  1  result register valid
- out_ready  in  1  downstream accepts result
- result  out  N  result (low half for MUL)
- result_hi  out  N  MUL high half; 0 for other ops
- flags  out  3  {C,Z,N} CCR, registered

Behaviour:
- Reset (rst_n=0, async): result=0, result_hi=0, out_valid=0, flags=0, state=IDLE.
- States:
  - IDLE: accepting.
  - MUL: iterating.
  - in_ready = (state==IDLE) && !flush && (!out_valid || out_ready).
- Accept: in_valid && in_ready. Ops 0–14 register result and flags on the accept edge, so out_valid rises the next cycle (latency 1).
- out_valid stays high with result stable until out_ready. Back-to-back accepts are allowed when out_ready=1 (throughput 1 op/cycle).
- Opcodes and results:
  - 0 NOP: result unchanged.
  - 1 NOT: ~src.
  - 2 INC: src+1.
  - 3 DEC: src-1.
  - 4 MOV: src.
  - 5 ADD: src+dst.
  - 6 SUB: src-dst.
  - 7 AND: src&dst.
  - 8 OR: src|dst.
  - 9 SHL: src<<imm[SHAMT_W-1:0].
  - 10 SHR: src>>imm[SHAMT_W-1:0].
  - 11 SETC: C=1.
  - 12 CLRC: C=0.
  - 13 PASS: src (load/store address).
  - 14 LDM: imm.
  - 15 MUL: unsigned src*dst.
- Every accepted op, including NOP, SETC and CLRC, produces one out_valid beat.
- Carry rules:
  - INC/ADD: C = carry-out.
  - SUB: C = borrow (src<dst unsigned).
  - DEC: C = (src==0).
  - SHL/SHR: C = last bit shifted out.
  - Shift amount 0: result=src, C unchanged.
  - Shift amount ≥N: result=0, C=0.
- Z/N rules:
  - Ops 1–3 and 5–10: Z = (result==0), N = result[N-1].
  - Ops 1, 7, 8: C unchanged.
  - Ops 0, 4, 13, 14: flags unchanged.
- MUL:
  - On accept, go to MUL and load a counter with N.
  - Shift-add runs 1 bit/cycle. The final step writes {result_hi,result}, then out_valid=1 and state returns to IDLE.
  - Total latency N+1 cycles from accept. in_ready=0 throughout.
  - Flags: C = |result_hi; Z = full 2N-bit product ==0; N = result[N-1].
- Flush:
  - Clears out_valid and returns to IDLE, aborting any MUL. Partial product is discarded; flags are not written.
  - result/result_hi keep their old values. CCR is retained.
  - flush together with in_valid: flush wins, nothing is accepted.
- Reset mid-MUL: all state returns to reset values immediately.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: op 15 is the iterative multiplier described above.
- Undefined: no multiplier logic and no MUL state. Op 15 behaves as NOP (latency 1, flags unchanged), and result_hi is tied to 0.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_NOP..OP_MUL;
  - flag index constants FLAG_C=2, FLAG_Z=1, FLAG_N=0;
  - state encoding ST_IDLE/ST_MUL.
- One natural sub-module: alu_mul_iter(N). Interface: start, operands, busy, done, 2N product, abort (driven by flush). Instantiated only under ALU_MUL_EN.

Test Plan:
- Reset then ADD: src=16'hFFFF, dst=1, out_ready=1 → next cycle result=0, flags C=1,Z=1,N=0, out_valid=1 for 1 cycle.
- SUB: src=3, dst=5 → result=16'hFFFE, C=1, Z=0, N=1. Then SHL src=16'h8001, imm=1 → result=2, C=1.
- Backpressure: ADD accepted, out_ready=0 for 3 cycles → result stable, in_ready=0. Then out_ready=1 → next op accepted that cycle.
- MUL (ALU_MUL_EN): src=16'h1234, dst=16'h0100 → out_valid exactly 17 cycles after accept, result=16'h3400, result_hi=16'h0012, C=1, in_ready=0 meanwhile.
- Flush at cycle 5 of MUL → out_valid stays 0, flags unchanged, in_ready=1 next cycle. Then NOP → flags unchanged, out_valid pulse.
- Async reset asserted mid-MUL → flags=0, out_valid=0, in_ready=1 after release. Without ALU_MUL_EN, op 15 → latency 1, flags unchanged.
